seq_pattern_gen: RTL and testbench

Bit-serial pattern generator: the transmit end of the serial sequence-detection path. It loads a pattern word once per `start`, then emits it MSB-first, one bit per clock, for a programmable number of passes. An optional idle gap separates consecutive passes. Its `out` drives the `x` input of the sequence detectors, both in system use and in detector benches.

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_down_counter.sv | 26 ++
 rtl/seq_pattern_gen.sv | 163 ++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and default widths for the serial pattern path
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down counter that holds at zero
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - MSB-first bit-serial pattern generator with repeat passes and idle gaps
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] rpt_q;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] pass_cnt;

    logic             idx_load, idx_en, idx_zero;
    logic [LEN_W-1:0] idx_val, idx;
    logic             gap_load, gap_en, gap_zero;
    logic [CNT_W-1:0] gap_cnt;
    logic             start_ok, last_pass, gap_last;

    function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign start_ok  = start && (len != '0) && (len <= WIDTH_L);
    assign last_pass = (pass_cnt == rpt_q);
    assign gap_last  = (gap_cnt == ONE_C);

    always_comb begin
        idx_load = 1'b0;
        idx_en   = 1'b0;
        idx_val  = len_q - ONE_L;
        gap_load = 1'b0;
        gap_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    idx_load = 1'b1;
                    idx_val  = len - ONE_L;
                end
            end
            SEND: begin
                if (!idx_zero) begin
                    idx_en = 1'b1;
                end else if (!last_pass) begin
                    if (gap_q == '0) idx_load = 1'b1;
                    else             gap_load = 1'b1;
                end
            end
            GAP: begin
                gap_en   = !gap_zero;
                idx_load = gap_last;
            end
            default: ;
        endcase
    end

    seq_down_counter #(.W(LEN_W)) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .en       (idx_en),
        .load_val (idx_val),
        .count    (idx),
        .zero     (idx_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .en       (gap_en),
        .load_val (gap_q),
        .count    (gap_cnt),
        .zero     (gap_zero)
    );

    // Outputs are computed for the state being entered, so they line up with it cycle for cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            rpt_q    <= '0;
            gap_q    <= '0;
            pass_cnt <= '0;
            out      <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_ok) begin
                        pat_q    <= pattern;
                        len_q    <= len;
                        rpt_q    <= repeat_cnt;
                        gap_q    <= gap;
                        pass_cnt <= '0;
                        state    <= SEND;
                        out      <= bit_at(pattern, len - ONE_L);
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (!idx_zero) begin
                        out <= bit_at(pat_q, idx - ONE_L);
                    end else if (last_pass) begin
                        state <= DONE;
                        out   <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pass_cnt <= pass_cnt + 1'b1;
                        if (gap_q == '0) begin
                            out <= bit_at(pat_q, len_q - ONE_L);
                        end else begin
                            state <= GAP;
                            out   <= 1'b0;
                            valid <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state <= SEND;
                        out   <= bit_at(pat_q, len_q - ONE_L);
                        valid <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for seq_pattern_gen
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_cnt;
    logic [3:0] gap;
    logic       out, valid, busy, done;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       exp_q[$];
    logic       e_bit;
    logic [2:0] hist;
    int         bitno;
    logic [15:0] det_mask;

    always #5 clk = ~clk;

    seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .out        (out),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop plus a behavioural 101 detector fed from the serial stream.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_bit", 64'd1, 64'd0);
            end else begin
                e_bit = exp_q.pop_front();
                check("bit", {63'd0, out}, {63'd0, e_bit});
            end
            bitno++;
            if ({hist[1:0], out} == 3'b101 && bitno < 16) det_mask[bitno] = 1'b1;
            hist = {hist[1:0], out};
        end
    end

    task automatic run_xfer(input string tag, input logic [7:0] p, input logic [3:0] l,
                            input logic [3:0] r, input logic [3:0] g,
                            input bit hold, input bit change);
        int exp_busy, pos, busy_n, done_n;
        logic [63:0] exp_v, got_v;
        bit fin;
        exp_busy = (int'(r) + 1) * int'(l) + int'(r) * int'(g);
        exp_v = '0;
        pos = 0;
        for (int ps = 0; ps <= int'(r); ps++) begin
            for (int i = int'(l) - 1; i >= 0; i--) begin
                exp_v[pos] = 1'b1;
                pos++;
                exp_q.push_back(p[i]);
            end
            if (ps < int'(r)) pos += int'(g);
        end
        hist = '0; bitno = 0; det_mask = '0;
        @(posedge clk); #1;
        pattern = p; len = l; repeat_cnt = r; gap = g; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        if (change) begin
            pattern = ~p; len = 4'd2; repeat_cnt = 4'd0; gap = 4'd5;
        end
        got_v = '0; busy_n = 0; done_n = 0; fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (c < 64) got_v[c] = valid;
            if (done) begin
                done_n++;
                check({tag, "_done_cycle"}, 64'(c), 64'(exp_busy));
                start = 1'b0;
                fin = 1;
            end
        end
        if (!fin) check({tag, "_timeout"}, 64'd1, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) done_n++;
            if (busy) busy_n++;
        end
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        check({tag, "_done_count"}, 64'(done_n), 64'd1);
        check({tag, "_valid_seq"}, got_v, exp_v);
        check({tag, "_bits_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic try_illegal(input string tag, input logic [3:0] l);
        logic agg;
        agg = 1'b0;
        @(posedge clk); #1;
        pattern = 8'hFF; len = l; repeat_cnt = 4'd1; gap = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            agg = agg | busy | valid | done;
        end
        check(tag, {63'd0, agg}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; len = '0; repeat_cnt = '0; gap = '0;
        hist = '0; bitno = 0; det_mask = '0;
        #3;
        check("reset_async", {60'd0, out, valid, busy, done}, 64'd0);
        @(negedge clk); @(negedge clk);
        check("reset_hold", {60'd0, out, valid, busy, done}, 64'd0);
        rst = 1'b0;

        run_xfer("single", 8'b0000_0101, 4'd3, 4'd0, 4'd0, 0, 0);
        run_xfer("loopback", 8'b0001_0101, 4'd5, 4'd0, 4'd0, 0, 0);
        check("loopback_det", {48'd0, det_mask}, 64'b10_1000);
        run_xfer("gap", 8'b0000_0011, 4'd2, 4'd2, 4'd3, 0, 0);
        try_illegal("illegal_len0", 4'd0);
        try_illegal("illegal_len9", 4'd9);
        run_xfer("hold_start", 8'b1011_0010, 4'd6, 4'd1, 4'd2, 1, 0);
        run_xfer("change_mid", 8'b1100_1010, 4'd8, 4'd1, 4'd0, 0, 1);
        run_xfer("max_repeat", 8'b0000_0001, 4'd1, 4'd15, 4'd0, 0, 0);
        run_xfer("len1_gap", 8'b0000_0001, 4'd1, 4'd2, 4'd1, 0, 0);

        // Reset in the second SEND cycle.
        for (int i = 7; i >= 0; i--) exp_q.push_back(i < 6 ? 1'b0 : 1'b1);
        @(posedge clk); #1;
        pattern = 8'hC0; len = 4'd8; repeat_cnt = 4'd1; gap = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_send", {61'd0, out, valid, busy}, 64'b111);
        rst = 1'b1; #1;
        check("rst_send_async", {60'd0, out, valid, busy, done}, 64'd0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        run_xfer("after_rst_send", 8'hA5, 4'd8, 4'd0, 4'd0, 0, 0);

        // Reset in the middle of a gap.
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        @(posedge clk); #1;
        pattern = 8'b0000_0010; len = 4'd2; repeat_cnt = 4'd1; gap = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        check("pre_rst_gap", {62'd0, valid, busy}, 64'b01);
        rst = 1'b1; #1;
        check("rst_gap_async", {60'd0, out, valid, busy, done}, 64'd0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        run_xfer("after_rst_gap", 8'b0000_0110, 4'd3, 4'd1, 4'd2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
